comp_div_one: RTL and testbench

- Iterative complex divider; the inverse of comp_mul_one.
- Takes a 17-bit complex product P = p_r + j·p_i and an 8-bit complex divisor B = b_r + j·b_i, and returns Q = P / B as an 8-bit complex value.
- Sits downstream of comp_mul_one (same i_en/o_en pulse convention, same signed operand widths). Used to recover the original operand and as a self-check partner in the complex arithmetic datapath.

---
 rtl/comp_pkg.sv | 18 +
 rtl/div_step_u.sv | 23 ++
 rtl/comp_div_one.sv | 162 ++++++++++++++++
 tb/tb_comp_div_one.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared widths, FSM encoding and saturation limits for the complex arithmetic path
package comp_pkg;

  localparam int C_DW = 8;
  localparam int C_PW = 2 * C_DW + 1;
  localparam int C_NW = C_PW + C_DW + 1;

  localparam logic [C_DW-1:0] C_QMAX = {1'b0, {(C_DW-1){1'b1}}};
  localparam logic [C_DW-1:0] C_QMIN = {1'b1, {(C_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step_u.sv
// rtl/div_step_u.sv - one unsigned restoring-division step
module div_step_u #(
  parameter int DW = 8
) (
  input  logic [2*DW:0]   rem,
  input  logic            nbit,
  input  logic [2*DW-1:0] den,
  output logic [2*DW:0]   rem_n,
  output logic            qbit
);

  logic [2*DW+1:0] trial;
  logic [2*DW+1:0] den_x;

  always_comb begin
    trial = {rem, nbit};
    den_x = {2'b00, den};
    qbit  = (trial >= den_x);
    // rem < den on entry, so the restored remainder always fits back in 2*DW+1 bits
    rem_n = qbit ? (2*DW+1)'(trial - den_x) : (2*DW+1)'(trial);
  end

endmodule

// File: rtl/comp_div_one.sv
// rtl/comp_div_one.sv - iterative complex divider Q = P / B, one quotient bit per cycle
module comp_div_one
  import comp_pkg::*;
#(
  parameter int DW = C_DW,
  parameter int PW = 2 * DW + 1,
  parameter int NW = PW + DW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] p_r,
  input  logic [PW-1:0] p_i,
  input  logic [DW-1:0] b_r,
  input  logic [DW-1:0] b_i,
  input  logic          i_en,
  output logic [DW-1:0] o_q_r,
  output logic [DW-1:0] o_q_i,
  output logic          o_en,
  output logic          o_busy,
  output logic          o_dz,
  output logic          o_ovf
);

  localparam int CW = $clog2(NW);
  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [NW-1:0] NEG_LIM = NW'(Q_MIN);

  div_state_t state, state_n;
  logic busy_n;

  logic signed [PW-1:0] pr_q, pi_q;
  logic signed [DW-1:0] br_q, bi_q;
  logic [2*DW-1:0] den_q;
  logic [NW-1:0]   nm_r, nm_i;
  logic            neg_r, neg_i;
  logic [2*DW:0]   rem_r, rem_i;
  logic [CW-1:0]   cnt;

  logic signed [NW-1:0] pr_x, pi_x, br_x, bi_x, num_r_c, num_i_c;
  logic signed [2*DW-1:0] br_w, bi_w;
  logic [2*DW-1:0] den_c;
  logic [NW-1:0]   mag_r_c, mag_i_c;
  logic [2*DW:0]   rn_r, rn_i;
  logic            qb_r, qb_i;
  logic [DW:0]     sat_r, sat_i;

  function automatic logic [DW:0] sat(input logic [NW-1:0] mag, input logic neg);
    if (neg)
      return (mag > NEG_LIM) ? {1'b1, Q_MIN} : {1'b0, DW'(~mag + NW'(1))};
    else
      return (mag > NW'(Q_MAX)) ? {1'b1, Q_MAX} : {1'b0, DW'(mag)};
  endfunction

  always_comb begin
    pr_x    = NW'(pr_q);
    pi_x    = NW'(pi_q);
    br_x    = NW'(br_q);
    bi_x    = NW'(bi_q);
    br_w    = (2*DW)'(br_q);
    bi_w    = (2*DW)'(bi_q);
    num_r_c = pr_x * br_x + pi_x * bi_x;
    num_i_c = pi_x * br_x - pr_x * bi_x;
    den_c   = br_w * br_w + bi_w * bi_w;
    mag_r_c = num_r_c[NW-1] ? (~num_r_c + NW'(1)) : num_r_c;
    mag_i_c = num_i_c[NW-1] ? (~num_i_c + NW'(1)) : num_i_c;
    sat_r   = sat(nm_r, neg_r);
    sat_i   = sat(nm_i, neg_i);
  end

  // The numerator registers shift out dividend bits and shift in quotient bits
  div_step_u #(.DW(DW)) u_step_r (
    .rem(rem_r), .nbit(nm_r[NW-1]), .den(den_q), .rem_n(rn_r), .qbit(qb_r)
  );

  div_step_u #(.DW(DW)) u_step_i (
    .rem(rem_i), .nbit(nm_i[NW-1]), .den(den_q), .rem_n(rn_i), .qbit(qb_i)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (i_en) state_n = PREP;
      PREP: state_n = DIV;
      DIV:  if (cnt == '0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      o_q_r  <= '0;
      o_q_i  <= '0;
      o_en   <= 1'b0;
      o_busy <= 1'b0;
      o_dz   <= 1'b0;
      o_ovf  <= 1'b0;
      cnt    <= '0;
      pr_q   <= '0;
      pi_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      den_q  <= '0;
      nm_r   <= '0;
      nm_i   <= '0;
      neg_r  <= 1'b0;
      neg_i  <= 1'b0;
      rem_r  <= '0;
      rem_i  <= '0;
    end else begin
      state  <= state_n;
      o_busy <= busy_n;
      o_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en) begin
            pr_q <= p_r;
            pi_q <= p_i;
            br_q <= b_r;
            bi_q <= b_i;
          end
        end
        PREP: begin
          den_q <= den_c;
          nm_r  <= mag_r_c;
          nm_i  <= mag_i_c;
          neg_r <= num_r_c[NW-1];
          neg_i <= num_i_c[NW-1];
          rem_r <= '0;
          rem_i <= '0;
          cnt   <= CW'(NW - 1);
        end
        DIV: begin
          rem_r <= rn_r;
          rem_i <= rn_i;
          nm_r  <= {nm_r[NW-2:0], qb_r};
          nm_i  <= {nm_i[NW-2:0], qb_i};
          cnt   <= cnt - CW'(1);
        end
        DONE: begin
          o_en <= 1'b1;
          if (den_q == '0) begin
            o_q_r <= '0;
            o_q_i <= '0;
            o_dz  <= 1'b1;
            o_ovf <= 1'b0;
          end else begin
            o_q_r <= sat_r[DW-1:0];
            o_q_i <= sat_i[DW-1:0];
            o_dz  <= 1'b0;
            o_ovf <= sat_r[DW] | sat_i[DW];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_div_one.sv
// tb/tb_comp_div_one.sv - directed self-checking bench for comp_div_one
module tb_comp_div_one;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] p_r = '0, p_i = '0;
  logic [7:0]  b_r = '0, b_i = '0;
  logic        i_en = 1'b0;
  logic [7:0]  o_q_r, o_q_i;
  logic        o_en, o_busy, o_dz, o_ovf;

  int checks = 0;
  int failures = 0;

  comp_div_one dut (
    .clk(clk), .rst(rst), .p_r(p_r), .p_i(p_i), .b_r(b_r), .b_i(b_i),
    .i_en(i_en), .o_q_r(o_q_r), .o_q_i(o_q_i), .o_en(o_en),
    .o_busy(o_busy), .o_dz(o_dz), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int pr, input int pi, input int br, input int bi);
    p_r = 17'(pr);
    p_i = 17'(pi);
    b_r = 8'(br);
    b_i = 8'(bi);
  endtask

  task automatic run_div(input string tag, input int pr, input int pi, input int br, input int bi,
                         input int eqr, input int eqi, input int edz, input int eovf);
    int lat;
    @(negedge clk);
    drive(pr, pi, br, bi);
    i_en = 1'b1;
    @(posedge clk);
    #1;
    i_en = 1'b0;
    drive(0, 0, 0, 0);
    chk({tag, "_busy"}, int'(o_busy), 1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (o_en) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 28);
    chk({tag, "_qr"}, int'($signed(o_q_r)), eqr);
    chk({tag, "_qi"}, int'($signed(o_q_i)), eqi);
    chk({tag, "_dz"}, int'(o_dz), edz);
    chk({tag, "_ovf"}, int'(o_ovf), eovf);
    chk({tag, "_busy_en"}, int'(o_busy), 1);
  endtask

  initial begin
    int n_en;
    int qr_seen, qi_seen;
    int ar, ai, br, bi;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", int'({o_q_r, o_q_i, o_en, o_busy, o_dz, o_ovf}), 0);
    @(negedge clk);
    rst = 1'b1;

    run_div("inv1",   7,     9,     3, 2,   3,    1,    0, 0);
    run_div("inv_neg", -8,   38,    2, 5,   6,    4,    0, 0);
    run_div("trunc_p", 10,   0,     3, 0,   3,    0,    0, 0);
    run_div("trunc_n", -10,  0,     3, 0,   -3,   0,    0, 0);
    run_div("dz",      5,    5,     0, 0,   0,    0,    1, 0);
    run_div("ovf",     1000, -1000, 1, 0,   127,  -128, 0, 1);

    // second start while busy must be ignored
    @(negedge clk);
    drive(7, 9, 3, 2);
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    repeat (5) @(negedge clk);
    drive(-8, 38, 2, 5);
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    n_en = 0;
    qr_seen = 0;
    qi_seen = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      if (o_en) begin
        n_en++;
        qr_seen = int'($signed(o_q_r));
        qi_seen = int'($signed(o_q_i));
      end
    end
    chk("busy_ign_count", n_en, 1);
    chk("busy_ign_qr", qr_seen, 3);
    chk("busy_ign_qi", qi_seen, 1);

    // reset in the middle of DIV
    @(negedge clk);
    drive(-8, 38, 2, 5);
    i_en = 1'b1;
    @(posedge clk);
    #1;
    i_en = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outs", int'({o_q_r, o_q_i, o_en, o_busy, o_dz, o_ovf}), 0);
    @(negedge clk);
    rst = 1'b1;
    n_en = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_en) n_en++;
    end
    chk("midrst_no_en", n_en, 0);
    run_div("after_rst", 7, 9, 3, 2, 3, 1, 0, 0);

    // back-to-back starts on exact products: quotient must recover a
    for (int it = 0; it < 8; it++) begin
      ar = int'($urandom_range(255)) - 128;
      ai = int'($urandom_range(255)) - 128;
      do begin
        br = int'($urandom_range(255)) - 128;
        bi = int'($urandom_range(255)) - 128;
      end while (br == 0 && bi == 0);
      run_div($sformatf("b2b%0d", it), ar * br - ai * bi, ar * bi + ai * br, br, bi,
              ar, ai, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
